// File: rtl/fs_accel_pkg.sv
// Shared definitions for the accelerator datapath blocks: OFM writer state
// encodings, packing geometry and the partial-word byte-enable helper.
package fs_accel_pkg;

    typedef enum logic [1:0] {
        OFMW_IDLE  = 2'd0,
        OFMW_PACK  = 2'd1,
        OFMW_WRITE = 2'd2,
        OFMW_DONE  = 2'd3
    } ofmw_state_t;

    localparam int OFMW_LANES     = 3;
    localparam int BYTES_PER_WORD = 4;

    // Byte enables for a word holding nbytes valid bytes from byte 0 upward.
    function automatic logic [3:0] strb_mask(input logic [2:0] nbytes);
        logic [3:0] mask;
        case (nbytes)
            3'd1:    mask = 4'h1;
            3'd2:    mask = 4'h3;
            3'd3:    mask = 4'h7;
            default: mask = 4'hF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/fs_accel_byte_packer.sv
// One lane's 32-bit little-endian pack register: writes a byte at the given
// index and clears synchronously once its word has been written out.
module fs_accel_byte_packer
    import fs_accel_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        clr,
    input  logic        wr_en,
    input  logic [1:0]  idx,
    input  logic [7:0]  din,
    output logic [31:0] word
);

    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_byte
            logic [7:0] byte_reg;

            always_ff @(posedge clk) begin
                if (!resetn || clr) begin
                    byte_reg <= '0;
                end else if (wr_en && (idx == 2'(gi))) begin
                    byte_reg <= din;
                end
            end

            assign word[8*gi +: 8] = byte_reg;
        end
    endgenerate

endmodule

// File: rtl/fs_accel_ofm_writer.sv
// OFM writer: packs three 8-bit lanes into 32-bit words and writes each lane's
// word to its own region of the OFM SRAM, lane 0 then 1 then 2 per word group.
module fs_accel_ofm_writer
    import fs_accel_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base_0,
    input  logic [ADDR_W-1:0] cfg_base_1,
    input  logic [ADDR_W-1:0] cfg_base_2,
    input  logic [CNT_W-1:0]  cfg_num_px,
    input  logic [7:0]        px_di_0,
    input  logic [7:0]        px_di_1,
    input  logic [7:0]        px_di_2,
    input  logic              px_vld,
    output logic              px_rdy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_gnt,
    output logic              busy,
    output logic              done
);

    ofmw_state_t       state_reg, state_next;
    logic [ADDR_W-1:0] base_reg [OFMW_LANES];
    logic [CNT_W-1:0]  num_px_reg;
    logic [CNT_W-1:0]  byte_cnt_reg;
    logic [ADDR_W-1:0] word_idx_reg;
    logic [1:0]        lane_reg;

    logic [7:0]  lane_di   [OFMW_LANES];
    logic [31:0] pack_word [OFMW_LANES];

    logic       accept;
    logic       last_byte;
    logic       word_full;
    logic       lane_last;
    logic       write_gnt;
    logic       group_done;
    logic       all_bytes;
    logic [2:0] nbytes;

    assign lane_di[0] = px_di_0;
    assign lane_di[1] = px_di_1;
    assign lane_di[2] = px_di_2;

    assign accept     = (state_reg == OFMW_PACK) && px_vld;
    assign last_byte  = (byte_cnt_reg == num_px_reg - CNT_W'(1));
    assign word_full  = (byte_cnt_reg[1:0] == 2'd3);
    assign lane_last  = (lane_reg == 2'd2);
    assign write_gnt  = (state_reg == OFMW_WRITE) && mem_gnt;
    assign group_done = write_gnt && lane_last;
    assign all_bytes  = (byte_cnt_reg == num_px_reg);
    // byte_cnt already counts the word's last byte while in WRITE; 0 mod 4 means full.
    assign nbytes     = (byte_cnt_reg[1:0] == 2'd0) ? 3'd4 : {1'b0, byte_cnt_reg[1:0]};

    genvar gi;
    generate
        for (gi = 0; gi < OFMW_LANES; gi++) begin : g_lane
            fs_accel_byte_packer u_packer (
                .clk    (clk),
                .resetn (resetn),
                .clr    (group_done),
                .wr_en  (accept),
                .idx    (byte_cnt_reg[1:0]),
                .din    (lane_di[gi]),
                .word   (pack_word[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= OFMW_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            OFMW_IDLE: begin
                if (start) begin
                    state_next = (cfg_num_px == '0) ? OFMW_DONE : OFMW_PACK;
                end
            end
            OFMW_PACK: begin
                if (accept && (word_full || last_byte)) begin
                    state_next = OFMW_WRITE;
                end
            end
            OFMW_WRITE: begin
                if (group_done) begin
                    state_next = all_bytes ? OFMW_DONE : OFMW_PACK;
                end
            end
            OFMW_DONE: state_next = OFMW_IDLE;
            default:   state_next = OFMW_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < OFMW_LANES; i++) begin
                base_reg[i] <= '0;
            end
            num_px_reg   <= '0;
            byte_cnt_reg <= '0;
            word_idx_reg <= '0;
            lane_reg     <= '0;
        end else begin
            if ((state_reg == OFMW_IDLE) && start) begin
                base_reg[0]  <= cfg_base_0;
                base_reg[1]  <= cfg_base_1;
                base_reg[2]  <= cfg_base_2;
                num_px_reg   <= cfg_num_px;
                byte_cnt_reg <= '0;
                word_idx_reg <= '0;
                lane_reg     <= '0;
            end
            if (accept) begin
                byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
            end
            if (write_gnt) begin
                lane_reg <= lane_last ? 2'd0 : lane_reg + 2'd1;
                if (lane_last) begin
                    word_idx_reg <= word_idx_reg + ADDR_W'(1);
                end
            end
        end
    end

    always_comb begin
        px_rdy    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_reg)
            OFMW_PACK: begin
                px_rdy = 1'b1;
                busy   = 1'b1;
            end
            OFMW_WRITE: begin
                mem_we    = 1'b1;
                busy      = 1'b1;
                mem_addr  = base_reg[lane_reg] + word_idx_reg;
                mem_wdata = pack_word[lane_reg];
                mem_wstrb = strb_mask(nbytes);
            end
            OFMW_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fs_accel_ofm_writer.sv
// Directed bench for the OFM writer: full and partial words, grant stalls,
// zero-length transfers, reset mid-write and start pulses while busy.
module tb_fs_accel_ofm_writer;

    logic        clk = 1'b0;
    logic        resetn, start, px_vld, mem_gnt;
    logic [15:0] cfg_base_0, cfg_base_1, cfg_base_2, cfg_num_px;
    logic [7:0]  px_di_0, px_di_1, px_di_2;
    logic        px_rdy, mem_we, busy, done;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_gnt_cyc = 0;
    logic [15:0] wa[$];
    logic [31:0] wd[$];
    logic [3:0]  ws[$];

    always #5 clk = ~clk;

    fs_accel_ofm_writer #(.ADDR_W(16), .CNT_W(16)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .cfg_base_0 (cfg_base_0),
        .cfg_base_1 (cfg_base_1),
        .cfg_base_2 (cfg_base_2),
        .cfg_num_px (cfg_num_px),
        .px_di_0    (px_di_0),
        .px_di_1    (px_di_1),
        .px_di_2    (px_di_2),
        .px_vld     (px_vld),
        .px_rdy     (px_rdy),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_gnt    (mem_gnt),
        .busy       (busy),
        .done       (done)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change only just after posedge, so at negedge we see what the next edge will take.
    always @(negedge clk) begin
        if (resetn && mem_we && mem_gnt) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            ws.push_back(mem_wstrb);
            last_gnt_cyc = cyc;
            $display("write addr=%h data=%h strb=%h", mem_addr, mem_wdata, mem_wstrb);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic clear_log();
        wa.delete();
        wd.delete();
        ws.delete();
    endtask

    task automatic do_start(input int n, input logic [15:0] b0, input logic [15:0] b1,
                            input logic [15:0] b2);
        cfg_num_px = 16'(n);
        cfg_base_0 = b0;
        cfg_base_1 = b1;
        cfg_base_2 = b2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic set_px(input int i);
        px_di_0 = 8'((i + 1) * 17);
        px_di_1 = 8'((i + 1) * 17 + 64);
        px_di_2 = 8'((i + 1) * 17 + 128);
    endtask

    task automatic feed_bytes(input int n, output bit to);
        int i = 0;
        int budget = 0;
        bit acc;
        set_px(0);
        px_vld = 1'b1;
        while (i < n && budget < 200) begin
            @(negedge clk);
            acc = px_rdy;
            @(posedge clk); #1;
            budget++;
            if (acc) begin
                i++;
                if (i < n) set_px(i);
            end
        end
        px_vld = 1'b0;
        to = (i < n);
    endtask

    task automatic wait_done(input int d0, output bit to);
        int budget = 0;
        while (done_cnt == d0 && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        to = (done_cnt == d0);
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; px_vld = 1'b0; mem_gnt = 1'b0;
        cfg_base_0 = '0; cfg_base_1 = '0; cfg_base_2 = '0; cfg_num_px = '0;
        px_di_0 = '0; px_di_1 = '0; px_di_2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({px_rdy, mem_we, busy, done} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl got rdy/we/busy/done=%b want 0000", {px_rdy, mem_we, busy, done});
        end
        checks++;
        if ({mem_addr, mem_wdata, mem_wstrb} !== 52'd0) begin
            errors++;
            $display("FAIL reset_port got addr=%h data=%h strb=%h want 0", mem_addr, mem_wdata, mem_wstrb);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_word();
        logic [15:0] ea [3];
        logic [31:0] ed [3];
        int d0;
        bit to1, to2;
        ea = '{16'h100, 16'h200, 16'h300};
        ed = '{32'h44332211, 32'h84736251, 32'hC4B3A291};
        clear_log();
        d0 = done_cnt;
        mem_gnt = 1'b1;
        do_start(4, 16'h100, 16'h200, 16'h300);
        feed_bytes(4, to1);
        wait_done(d0, to2);
        checks++;
        if (to1 || to2) begin
            errors++;
            $display("FAIL t1_timeout got feed_to=%0d done_to=%0d want 0 0", to1, to2);
        end
        checks++;
        if (wa.size() != 3) begin
            errors++;
            $display("FAIL t1_count got %0d writes want 3", wa.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wa[i] !== ea[i] || wd[i] !== ed[i] || ws[i] !== 4'hF) begin
                    errors++;
                    $display("FAIL t1_write%0d got %h:%h/%h want %h:%h/f", i, wa[i], wd[i], ws[i], ea[i], ed[i]);
                end
            end
        end
        checks++;
        if (done_cyc !== last_gnt_cyc + 1 || done_cnt !== d0 + 1) begin
            errors++;
            $display("FAIL t1_done_time got cyc=%0d pulses=%0d want cyc=%0d pulses=1",
                     done_cyc, done_cnt - d0, last_gnt_cyc + 1);
        end
    endtask

    task automatic test_partial_word();
        logic [15:0] ea [6];
        logic [31:0] ed [6];
        logic [3:0]  es [6];
        int d0;
        bit to1, to2;
        ea = '{16'h100, 16'h200, 16'h300, 16'h101, 16'h201, 16'h301};
        ed = '{32'h44332211, 32'h84736251, 32'hC4B3A291, 32'h00006655, 32'h0000A695, 32'h0000E6D5};
        es = '{4'hF, 4'hF, 4'hF, 4'h3, 4'h3, 4'h3};
        clear_log();
        d0 = done_cnt;
        mem_gnt = 1'b1;
        do_start(6, 16'h100, 16'h200, 16'h300);
        feed_bytes(6, to1);
        wait_done(d0, to2);
        checks++;
        if (to1 || to2 || wa.size() != 6) begin
            errors++;
            $display("FAIL t2_count got to=%0d/%0d writes=%0d want 0/0 6", to1, to2, wa.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (wa[i] !== ea[i] || wd[i] !== ed[i] || ws[i] !== es[i]) begin
                    errors++;
                    $display("FAIL t2_write%0d got %h:%h/%h want %h:%h/%h", i, wa[i], wd[i], ws[i], ea[i], ed[i], es[i]);
                end
            end
        end
    endtask

    task automatic test_gnt_stall();
        int d0;
        bit to1, to2;
        clear_log();
        d0 = done_cnt;
        mem_gnt = 1'b0;
        do_start(4, 16'h010, 16'h020, 16'h030);
        feed_bytes(4, to1);
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({mem_we, mem_addr, mem_wdata, mem_wstrb, px_rdy} !==
                {1'b1, 16'h020, 32'h84736251, 4'hF, 1'b0}) begin
                errors++;
                $display("FAIL t3_stall%0d got we=%b addr=%h data=%h strb=%h rdy=%b want 1 0020 84736251 f 0",
                         k, mem_we, mem_addr, mem_wdata, mem_wstrb, px_rdy);
            end
        end
        @(posedge clk); #1;
        mem_gnt = 1'b1;
        wait_done(d0, to2);
        checks++;
        if (to1 || to2 || wa.size() != 3) begin
            errors++;
            $display("FAIL t3_count got to=%0d/%0d writes=%0d want 0/0 3", to1, to2, wa.size());
        end else begin
            checks++;
            if (wa[1] !== 16'h020 || wa[2] !== 16'h030 || wd[2] !== 32'hC4B3A291) begin
                errors++;
                $display("FAIL t3_after got %h %h:%h want 0020 0030:c4b3a291", wa[1], wa[2], wd[2]);
            end
        end
    endtask

    task automatic test_zero_len();
        int d0;
        clear_log();
        d0 = done_cnt;
        mem_gnt = 1'b1;
        do_start(0, 16'h100, 16'h200, 16'h300);
        @(negedge clk);
        checks++;
        if ({done, busy, mem_we} !== 3'b110) begin
            errors++;
            $display("FAIL t4_pulse got done/busy/we=%b want 110", {done, busy, mem_we});
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL t4_after got done/busy=%b want 00", {done, busy});
        end
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (wa.size() != 0 || done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL t4_nowrite got writes=%0d pulses=%0d want 0 1", wa.size(), done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] ed [3];
        int d0;
        bit to1, to2;
        ed = '{32'h44332211, 32'h84736251, 32'hC4B3A291};
        clear_log();
        mem_gnt = 1'b0;
        do_start(4, 16'h100, 16'h200, 16'h300);
        feed_bytes(4, to1);
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || to1) begin
            errors++;
            $display("FAIL t5_inwrite got we=%b to=%0d want 1 0", mem_we, to1);
        end
        @(posedge clk); #1;
        resetn = 1'b0;
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({px_rdy, mem_we, busy, done, mem_addr, mem_wdata, mem_wstrb} !== 56'd0) begin
            errors++;
            $display("FAIL t5_reset got rdy=%b we=%b busy=%b done=%b addr=%h data=%h strb=%h want all 0",
                     px_rdy, mem_we, busy, done, mem_addr, mem_wdata, mem_wstrb);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (wa.size() != 0) begin
            errors++;
            $display("FAIL t5_nowrite got %0d writes want 0", wa.size());
        end
        d0 = done_cnt;
        do_start(4, 16'h100, 16'h200, 16'h300);
        feed_bytes(4, to1);
        wait_done(d0, to2);
        checks++;
        if (to1 || to2 || wa.size() != 3) begin
            errors++;
            $display("FAIL t5_restart got to=%0d/%0d writes=%0d want 0/0 3", to1, to2, wa.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wa[i] !== 16'(16'h100 * (i + 1)) || wd[i] !== ed[i]) begin
                    errors++;
                    $display("FAIL t5_write%0d got %h:%h want %h:%h", i, wa[i], wd[i], 16'(16'h100 * (i + 1)), ed[i]);
                end
            end
        end
    endtask

    task automatic test_start_busy();
        int d0;
        bit to1, to2;
        clear_log();
        d0 = done_cnt;
        mem_gnt = 1'b0;
        set_px(7);
        px_vld = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (px_rdy !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL t6_idle%0d got rdy=%b busy=%b want 0 0", k, px_rdy, busy);
            end
            @(posedge clk); #1;
        end
        px_vld = 1'b0;
        do_start(4, 16'h400, 16'h500, 16'h600);
        feed_bytes(4, to1);
        do_start(8, 16'h700, 16'h800, 16'h900);
        mem_gnt = 1'b1;
        wait_done(d0, to2);
        repeat (5) begin @(posedge clk); #1; end
        checks++;
        if (to1 || to2 || wa.size() != 3 || done_cnt != d0 + 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t6_count got to=%0d/%0d writes=%0d pulses=%0d busy=%b want 0/0 3 1 0",
                     to1, to2, wa.size(), done_cnt - d0, busy);
        end else begin
            checks++;
            if (wa[0] !== 16'h400 || wa[1] !== 16'h500 || wa[2] !== 16'h600 ||
                wd[0] !== 32'h44332211 || wd[2] !== 32'hC4B3A291) begin
                errors++;
                $display("FAIL t6_writes got %h:%h %h %h:%h want 0400:44332211 0500 0600:c4b3a291",
                         wa[0], wd[0], wa[1], wa[2], wd[2]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_partial_word();
        test_gnt_stall();
        test_zero_len();
        test_reset_mid();
        test_start_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish by %0t want finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
